// File: rtl/cache_mem_req_arb_pkg.sv
// Shared definitions for the cached-memory request arbiter.
//   - requester index constants (I$ = 0, D$ = 1)
//   - width derivation helpers for the requester index and the outgoing TID
//   - mem_req_t: one request slot for the default configuration
package cache_arb_pkg;

  localparam int ICACHE_IDX = 0;
  localparam int DCACHE_IDX = 1;

  localparam int DEF_NUM_REQ       = 2;
  localparam int DEF_TID_WIDTH     = 2;
  localparam int DEF_PAYLOAD_WIDTH = 200;

  // Requester index width; at least one bit even for a single requester.
  function automatic int idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Outgoing TID = {requester index, requester-local TID}.
  function automatic int out_tid_w(input int num_req, input int tid_width);
    return idx_w(num_req) + tid_width;
  endfunction

  localparam int DEF_OUT_TID_W = out_tid_w(DEF_NUM_REQ, DEF_TID_WIDTH);

  typedef struct packed {
    logic                         write;
    logic [DEF_OUT_TID_W-1:0]     tid;
    logic [DEF_PAYLOAD_WIDTH-1:0] payload;
  } mem_req_t;

endpackage

// File: rtl/cache_mem_req_arb_if.sv
// Downstream channel of the arbiter: request slot towards the AXI adapter and
// the response / write-ack return path.
//   master : the arbiter (drives mem_*_o, receives mem_ready_i and rtrn_*_i)
//   slave  : the downstream adapter
// Signal names carry the direction as seen from the arbiter.
interface cache_mem_req_arb_if
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int TID_WIDTH     = 2,
  parameter int PAYLOAD_WIDTH = 200
);
  localparam int OUT_TID_W = out_tid_w(NUM_REQ, TID_WIDTH);

  logic                     mem_valid_o;
  logic                     mem_ready_i;
  logic                     mem_write_o;
  logic [OUT_TID_W-1:0]     mem_tid_o;
  logic [PAYLOAD_WIDTH-1:0] mem_payload_o;
  logic                     rtrn_valid_i;
  logic [OUT_TID_W-1:0]     rtrn_tid_i;

  modport master (
    output mem_valid_o, mem_write_o, mem_tid_o, mem_payload_o,
    input  mem_ready_i, rtrn_valid_i, rtrn_tid_i
  );

  modport slave (
    input  mem_valid_o, mem_write_o, mem_tid_o, mem_payload_o,
    output mem_ready_i, rtrn_valid_i, rtrn_tid_i
  );
endinterface

// File: rtl/cache_mem_req_arb_rr_arb_nb.sv
// Round-robin pick over NUM_REQ requesters with a registered pointer.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : a grant may be issued this cycle
//   req_i         : request vector
//   gnt_o         : one-hot grant (zero when en_i is low or nothing requests)
//   idx_o         : index of the granted requester
// The pointer moves to one past the winner whenever a grant is issued.
module rr_arb_nb
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from the pointer, wrapping, and take the first requester seen.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cache_mem_req_arb.sv
// Shares the cached-memory request channel between the I$ refill path (0) and
// the D$ miss / write-buffer path (1).
//   clk_i, rst_ni   : clock, async active-low reset
//   req_valid_i     : per-requester transaction present
//   req_ready_o     : per-requester accept strobe (at most one set)
//   req_write_i     : per-requester write flag
//   req_tid_i       : per-requester local TID, packed
//   req_payload_i   : per-requester payload, packed
//   rtrn_valid_o    : one-hot response strobe to the owning requester
//   rtrn_tid_o      : local TID of the response, broadcast
//   busy_o          : slot full or transactions still in flight
//   err_o           : sticky, response without outstanding transaction or bad index
//   mem_if          : downstream request slot and return channel
module cache_mem_req_arb
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int TID_WIDTH       = 2,
  parameter int PAYLOAD_WIDTH   = 200,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_write_i,
  input  logic [NUM_REQ*TID_WIDTH-1:0]     req_tid_i,
  input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]               rtrn_valid_o,
  output logic [TID_WIDTH-1:0]             rtrn_tid_o,
  output logic                             busy_o,
  output logic                             err_o,
  cache_mem_req_arb_if.master              mem_if
);

  localparam int IDX_W     = idx_w(NUM_REQ);
  localparam int OUT_TID_W = out_tid_w(NUM_REQ, TID_WIDTH);
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

  logic                     mem_valid_q, mem_valid_d;
  logic                     mem_write_q, mem_write_d;
  logic [OUT_TID_W-1:0]     mem_tid_q, mem_tid_d;
  logic [PAYLOAD_WIDTH-1:0] mem_payload_q, mem_payload_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;

  logic                     slot_free, credit, hs, dec, underflow, idx_ok;
  logic [CNT_W:0]           inflight;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic [IDX_W-1:0]         rtrn_idx;
  logic                     sel_write;
  logic [TID_WIDTH-1:0]     sel_tid;
  logic [PAYLOAD_WIDTH-1:0] sel_payload;

  assign slot_free = !mem_valid_q || mem_if.mem_ready_i;
  // The slot occupies a credit as soon as it is loaded.
  assign inflight  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, mem_valid_q};
  assign credit    = inflight < MAX_C;
  assign hs        = mem_valid_q && mem_if.mem_ready_i;
  assign dec       = mem_if.rtrn_valid_i && (cnt_q != '0);
  assign underflow = mem_if.rtrn_valid_i && (cnt_q == '0);

  rr_arb_nb #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (slot_free && credit),
    .req_i  (req_valid_i),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign req_ready_o = gnt;

  // AND-OR mux over the one-hot grant.
  always_comb begin
    sel_write   = 1'b0;
    sel_tid     = '0;
    sel_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_write   |= req_write_i[i] & gnt[i];
      sel_tid     |= req_tid_i[i*TID_WIDTH +: TID_WIDTH] & {TID_WIDTH{gnt[i]}};
      sel_payload |= req_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] & {PAYLOAD_WIDTH{gnt[i]}};
    end
  end

  // Slot contents hold while stalled; only a grant reloads them.
  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_write_d   = mem_write_q;
    mem_tid_d     = mem_tid_q;
    mem_payload_d = mem_payload_q;
    if (|gnt) begin
      mem_valid_d   = 1'b1;
      mem_write_d   = sel_write;
      mem_tid_d     = {gnt_idx, sel_tid};
      mem_payload_d = sel_payload;
    end else if (hs) begin
      mem_valid_d   = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({hs, dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign rtrn_idx   = mem_if.rtrn_tid_i[OUT_TID_W-1:TID_WIDTH];
  assign rtrn_tid_o = mem_if.rtrn_tid_i[TID_WIDTH-1:0];

  always_comb begin
    rtrn_valid_o = '0;
    idx_ok       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rtrn_idx == IDX_W'(i)) begin
        idx_ok          = 1'b1;
        rtrn_valid_o[i] = mem_if.rtrn_valid_i;
      end
    end
  end

  assign err_d = err_q || underflow || (mem_if.rtrn_valid_i && !idx_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_valid_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_tid_q     <= '0;
      mem_payload_q <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      mem_write_q   <= mem_write_d;
      mem_tid_q     <= mem_tid_d;
      mem_payload_q <= mem_payload_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
    end
  end

  assign mem_if.mem_valid_o   = mem_valid_q;
  assign mem_if.mem_write_o   = mem_write_q;
  assign mem_if.mem_tid_o     = mem_tid_q;
  assign mem_if.mem_payload_o = mem_payload_q;
  assign busy_o               = mem_valid_q || (cnt_q != '0);
  assign err_o                = err_q;

endmodule

// File: tb/tb_cache_mem_req_arb.sv
// Bench for cache_mem_req_arb: directed sequence with literal expectations plus
// a transaction-level model compared on every falling clock edge.
module tb_cache_mem_req_arb;
  import cache_arb_pkg::*;

  localparam int N    = 2;
  localparam int TW   = 2;
  localparam int PW   = 200;
  localparam int MAXO = 4;
  localparam int OTW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_write;
  logic [N*TW-1:0] req_tid;
  logic [PW-1:0]   pay0, pay1;
  logic [N*PW-1:0] req_payload;
  logic [N-1:0]    req_ready, rtrn_valid_o;
  logic [TW-1:0]   rtrn_tid_o;
  logic            busy, err;
  logic            mem_ready, rtrn_valid;
  logic [OTW-1:0]  rtrn_tid;

  int n_cmp = 0;
  int n_bad = 0;

  assign req_payload = {pay1, pay0};

  cache_mem_req_arb_if #(.NUM_REQ(N), .TID_WIDTH(TW), .PAYLOAD_WIDTH(PW)) mem_if ();
  assign mem_if.mem_ready_i  = mem_ready;
  assign mem_if.rtrn_valid_i = rtrn_valid;
  assign mem_if.rtrn_tid_i   = rtrn_tid;

  cache_mem_req_arb #(.NUM_REQ(N), .TID_WIDTH(TW), .PAYLOAD_WIDTH(PW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_write_i   (req_write),
    .req_tid_i     (req_tid),
    .req_payload_i (req_payload),
    .rtrn_valid_o  (rtrn_valid_o),
    .rtrn_tid_o    (rtrn_tid_o),
    .busy_o        (busy),
    .err_o         (err),
    .mem_if        (mem_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mkpay(input int r, input int s);
    return {100{2'(r + 1)}} ^ PW'(s);
  endfunction

  // ---------------- transaction-level model ----------------
  bit            m_sv;     // slot occupied
  logic          m_sw;
  logic [OTW-1:0] m_st;
  logic [PW-1:0] m_sp;
  int            m_cnt;    // transactions handed downstream and not yet answered
  bit            m_err;
  int            m_last;   // requester granted most recently

  // Who must be granted now: the requester after the last winner, in circular
  // order, provided the slot can take a request and total in-flight stays < MAXO.
  function automatic int exp_gnt();
    int r;
    if (m_sv && !mem_ready) return -1;
    if (m_cnt + (m_sv ? 1 : 0) >= MAXO) return -1;
    for (int k = 1; k <= N; k++) begin
      r = (m_last + k) % N;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    bit hs;
    if (!rst_n) begin
      m_sv = 0; m_sw = 0; m_st = '0; m_sp = '0; m_cnt = 0; m_err = 0; m_last = N - 1;
    end else begin
      g  = exp_gnt();
      hs = m_sv && mem_ready;
      if (rtrn_valid) begin
        if (m_cnt == 0) m_err = 1;
        else            m_cnt = m_cnt - 1;
        if (int'(rtrn_tid[OTW-1:TW]) >= N) m_err = 1;
      end
      if (hs) m_cnt = m_cnt + 1;
      if (g >= 0) begin
        m_sv   = 1;
        m_sw   = req_write[g];
        m_st   = OTW'(g * (1 << TW) + int'(req_tid[g*TW +: TW]));
        m_sp   = (g == 1) ? pay1 : pay0;
        m_last = g;
      end else if (hs) begin
        m_sv = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    int ri;
    g  = exp_gnt();
    ri = int'(rtrn_tid[OTW-1:TW]);
    chk("m_req_ready", req_ready, (g >= 0) ? PW'(1 << g) : '0);
    chk("m_mem_valid", mem_if.mem_valid_o, m_sv);
    chk("m_busy", busy, (m_sv || m_cnt != 0));
    chk("m_err", err, m_err);
    if (m_sv) begin
      chk("m_mem_tid", mem_if.mem_tid_o, m_st);
      chk("m_mem_write", mem_if.mem_write_o, m_sw);
      chk("m_mem_payload", mem_if.mem_payload_o, m_sp);
    end
    chk("m_rtrn_valid", rtrn_valid_o, (rtrn_valid && ri < N) ? PW'(1 << ri) : '0);
    chk("m_rtrn_tid", rtrn_tid_o, rtrn_tid[TW-1:0]);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0] t2_exp [6];
    t2_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};

    req_valid = '0; req_write = '0; req_tid = '0; pay0 = '0; pay1 = '0;
    mem_ready = 1'b1; rtrn_valid = 1'b0; rtrn_tid = '0; rst_n = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_mem_valid", mem_if.mem_valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_tid", mem_if.mem_tid_o, 0);
    chk("rst_mem_payload", mem_if.mem_payload_o, 0);
    rst_n = 1'b1;
    tick();

    // single read from I$
    req_valid = 2'b01; req_tid = 4'b0010; req_write = 2'b00; pay0 = mkpay(0, 1);
    #1 chk("t1_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    #1 chk("t1_mem_valid", mem_if.mem_valid_o, 1);
    chk("t1_mem_tid", mem_if.mem_tid_o, 3'b010);
    chk("t1_mem_payload", mem_if.mem_payload_o, mkpay(0, 1));
    tick();
    #1 chk("t1_slot_empty", mem_if.mem_valid_o, 0);
    chk("t1_busy_inflight", busy, 1);
    rtrn_valid = 1'b1; rtrn_tid = 3'b010;
    #1 chk("t1_rtrn_valid", rtrn_valid_o, 2'b01);
    chk("t1_rtrn_tid", rtrn_tid_o, 2);
    tick(); rtrn_valid = 1'b0;
    #1 chk("t1_busy_idle", busy, 0);
    chk("t1_err", err, 0);

    // both requesters, full throughput until credit runs out
    do_reset();
    req_valid = 2'b11; req_tid = {2'd3, 2'd1}; req_write = 2'b10;
    pay0 = mkpay(0, 2); pay1 = mkpay(1, 2);
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t2_ready_%0d", k), req_ready, t2_exp[k]);
      tick();
    end
    req_valid = 2'b00;
    #1 chk("t2_busy", busy, 1);
    chk("t2_slot_empty", mem_if.mem_valid_o, 0);

    // credit limit with simultaneous return and handshake
    rtrn_valid = 1'b1; rtrn_tid = 3'b001; req_valid = 2'b01; req_tid = {2'd3, 2'd0};
    #1 chk("t4_full_ready", req_ready, 2'b00);
    chk("t4_rtrn_strobe0", rtrn_valid_o, 2'b01);
    tick(); rtrn_valid = 1'b0; mem_ready = 1'b0;
    #1 chk("t4_credit_back", req_ready, 2'b01);
    tick(); req_valid = 2'b11; mem_ready = 1'b1; rtrn_valid = 1'b1; rtrn_tid = 3'b111;
    #1 chk("t4_both_ready", req_ready, 2'b00);
    chk("t4_slot_full", mem_if.mem_valid_o, 1);
    chk("t4_slot_tid", mem_if.mem_tid_o, 3'b000);
    chk("t4_rtrn_strobe1", rtrn_valid_o, 2'b10);
    chk("t4_rtrn_tid", rtrn_tid_o, 3);
    tick(); rtrn_valid = 1'b0; mem_ready = 1'b0;
    #1 chk("t4_grant_after_free", req_ready, 2'b10);
    chk("t4_slot_freed", mem_if.mem_valid_o, 0);

    // reset with slot full and three in flight
    tick(); req_valid = 2'b00;
    #1 chk("t6_slot_full", mem_if.mem_valid_o, 1);
    chk("t6_slot_tid", mem_if.mem_tid_o, 3'b111);
    chk("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1 chk("t6_mem_valid", mem_if.mem_valid_o, 0);
    chk("t6_busy", busy, 0);
    tick();
    rst_n = 1'b1; req_valid = 2'b11; req_tid = {2'd2, 2'd1}; req_write = 2'b01; pay0 = mkpay(0, 6);
    #1 chk("t6_ptr0", req_ready, 2'b01);
    tick();

    // stall with the slot full for five cycles
    pay0 = mkpay(0, 7);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t3_ready_%0d", k), req_ready, 2'b00);
      chk($sformatf("t3_valid_%0d", k), mem_if.mem_valid_o, 1);
      chk($sformatf("t3_tid_%0d", k), mem_if.mem_tid_o, 3'b001);
      chk($sformatf("t3_write_%0d", k), mem_if.mem_write_o, 1);
      chk($sformatf("t3_payload_%0d", k), mem_if.mem_payload_o, mkpay(0, 6));
      tick();
    end
    req_valid = 2'b00; mem_ready = 1'b1;
    tick();
    #1 chk("t3_released", mem_if.mem_valid_o, 0);
    chk("t3_busy", busy, 1);
    tick();
    #1 chk("t3_single_hs", mem_if.mem_valid_o, 0);
    rtrn_valid = 1'b1; rtrn_tid = 3'b001;
    tick(); rtrn_valid = 1'b0;
    #1 chk("t3_cnt_one", busy, 0);
    chk("t3_err", err, 0);

    // underflow
    rtrn_valid = 1'b1; rtrn_tid = 3'b110;
    #1 chk("t5_strobe", rtrn_valid_o, 2'b10);
    chk("t5_err_pre", err, 0);
    tick(); rtrn_valid = 1'b0;
    #1 chk("t5_err", err, 1);
    chk("t5_busy", busy, 0);
    repeat (3) tick();
    #1 chk("t5_err_sticky", err, 1);
    req_valid = 2'b01;
    #1 chk("t5_cnt_zero_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
